banked_lane_bram: RTL and testbench
===================================

# banked_lane_bram

Parametrised successor of the accelerator's simple dual-port BRAM: one write port with per-lane (byte) write enables, one read port with selectable 1- or 2-cycle latency and a `b_valid` strobe. After reset, an automatic zero-fill sweep initialises every location so weight and activation buffers start clean. It sits between the host/testbench loader (Port A) and the compute FSMs (Port B).

## Interface

Parameters:
- LANE_WIDTH, 8, bits per write lane.
- NUM_LANES, 4, lanes per word; DATA_WIDTH = LANE_WIDTH*NUM_LANES.
- ADDR_WIDTH, 6, DEPTH = 2^ADDR_WIDTH locations.
- READ_LATENCY, 1, legal values 1 or 2; any other value is an elaboration error.

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- init_busy  out  1  high while the zero-fill sweep runs.
- a_ready  out  1  equals !init_busy.
- a_wen  in  1  write request.
- a_be  in  NUM_LANES  per-lane write enable.
- a_addr  in  ADDR_WIDTH  write address.
- a_din  in  DATA_WIDTH  write data; lane i is bits [i*LANE_WIDTH +: LANE_WIDTH].
- b_en  in  1  read request.
- b_addr  in  ADDR_WIDTH  read address.
- b_dout  out  DATA_WIDTH  registered read data.
- b_valid  out  1  one-cycle pulse when b_dout carries new read data.

## Operation

- FSM states: SWEEP, READY. `rst` forces SWEEP and clears the sweep counter to 0.
- SWEEP: one location is written per cycle with all lanes zero, at counter 0..DEPTH-1. After the cycle that writes DEPTH-1, the FSM goes to READY. Otherwise SWEEP only exits on `rst`.
- Writes in SWEEP are dropped silently, including when a_wen=1. Reads in SWEEP are dropped: no b_valid, and b_dout holds.
- READY: if a_wen=1, each lane i with a_be[i]=1 is written. Lanes with a_be[i]=0 keep their old value. A write with a_wen=1 and a_be=0 is a no-op.
- READY read: b_en=1 samples b_addr. Data appears after READ_LATENCY cycles with b_valid=1. Back-to-back reads are fully pipelined, one per cycle.
- b_dout holds its last value whenever b_valid=0.
- Same-cycle same-address write and read: behaviour is set by the configuration macro; see Configuration.
- A write to an address one cycle after it was read (READ_LATENCY=2) does not affect that read. The memory is sampled in the first read stage.
- Reset during SWEEP restarts the sweep at address 0. Reset during READY discards in-flight reads, with no b_valid. Memory contents are rewritten by the new sweep.

## Timing

- Values while rst=1 and in the first cycle after: init_busy=1, a_ready=0, b_valid=0, b_dout=0. Pipeline registers are 0.
- Reset is released at edge E0, so the first cycle with rst=0 starts at E0. Sweep writes address k at edge E0+k+1. init_busy falls after edge E0+DEPTH. The first accepted access is in the cycle after that edge.
- Read latency: request at edge N gives b_valid and data after edge N+READ_LATENCY.

## Configuration

- Macro: BANKED_LANE_BRAM_BYPASS_EN.
- Defined: a same-cycle, same-address read in READY returns write-first data. Enabled lanes carry the new a_din lanes; the other lanes carry the old contents. This is built with a forwarding mux on the first read stage.
- Undefined: read-first. The read returns the contents from before the write, and the write still completes. There is no forwarding logic.

## Structure

- Shared package `bram_pkg` holds:
  - the state encoding (SWEEP, READY);
  - the legal READ_LATENCY constants;
  - the function computing DATA_WIDTH from LANE_WIDTH and NUM_LANES.
- Sub-module `bram_lane` is one LANE_WIDTH x DEPTH memory slice with its own write enable and a registered read. It is instantiated NUM_LANES times by generate. Sweep, forwarding, latency pipeline and valid logic stay in the top module.

## Test plan

All scenarios use the defaults unless stated.

- Reset then sweep: release rst.
  - init_busy stays 1 for exactly 64 cycles.
  - Reading addresses 0..63 afterwards returns 0x00000000 each time, with one b_valid per read.
- Byte-enable write: write 0xAABBCCDD to address 5 with a_be=4'b1111, then write 0x11223344 with a_be=4'b0101. A read of address 5 returns 0xAA22CC44.
- Latency 2: set READ_LATENCY=2 and issue reads of addresses 1, 2, 3 on consecutive cycles. b_valid is high on 3 consecutive cycles starting 2 cycles after the first request, with data in request order.
- Collision: address 9 holds 0x0. In one cycle, write 0xDEADBEEF with a_be=4'b1100 and read address 9.
  - With BANKED_LANE_BRAM_BYPASS_EN the read returns 0xDEAD0000.
  - Without it the read returns 0x00000000; a subsequent read returns 0xDEAD0000.
- Access during sweep: drive a_wen to address 3 and b_en while init_busy=1. No b_valid occurs, and address 3 reads 0 after the sweep.
- Reset mid-operation: assert rst at sweep address 30, or with a read in flight.
  - The in-flight read produces no b_valid.
  - The sweep restarts, and init_busy lasts 64 cycles from the new release.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and constants for the banked lane BRAM: FSM encoding,
// legal read latencies and the word-width helper.
package bram_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    function automatic int calc_data_width(input int lane_width, input int num_lanes);
        return lane_width * num_lanes;
    endfunction

endpackage

// File: rtl/bram_lane.sv
// One LANE_WIDTH x DEPTH memory slice with its own write enable.
// Latency: registered read, data one cycle after re; rdat holds when re=0.
// Backpressure: none; always accepts a write and a read every cycle.
module bram_lane #(
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [LANE_WIDTH-1:0] wdat,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [LANE_WIDTH-1:0] rdat
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [LANE_WIDTH-1:0] mem [DEPTH];

    // Storage carries no reset so it maps onto block RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdat <= '0;
        end else if (re) begin
            rdat <= mem[raddr];
        end
    end

endmodule

// File: rtl/banked_lane_bram.sv
// Lane-enabled simple dual-port RAM with post-reset zero-fill; macro BANKED_LANE_BRAM_BYPASS_EN selects write-first collisions.
// Latency: READ_LATENCY (1 or 2) cycles from read request to b_valid; zero-fill takes DEPTH cycles.
// Backpressure: a_ready low during zero-fill; writes and reads issued then are dropped, no stall otherwise.
module banked_lane_bram
    import bram_pkg::*;
#(
    parameter  int LANE_WIDTH   = 8,
    parameter  int NUM_LANES    = 4,
    parameter  int ADDR_WIDTH   = 6,
    parameter  int READ_LATENCY = RD_LAT_1,
    localparam int DATA_WIDTH   = calc_data_width(LANE_WIDTH, NUM_LANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic                  a_ready,
    input  logic                  a_wen,
    input  logic [NUM_LANES-1:0]  a_be,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid
);

    generate
        if (READ_LATENCY != RD_LAT_1 && READ_LATENCY != RD_LAT_2) begin : g_bad_latency
            $error("banked_lane_bram: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic                    sweeping;
    logic                    wr_ok;
    logic                    rd_acc;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   lane_rdat;
    logic [DATA_WIDTH-1:0]   s1_dat;
    logic                    s1_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                SWEEP: begin
                    sweep_cnt <= sweep_cnt + ADDR_WIDTH'(1);
                    if (&sweep_cnt) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

    assign a_ready  = ~init_busy;
    assign sweeping = (state == SWEEP) && !rst;
    assign wr_ok    = (state == READY) && !rst && a_wen;
    assign rd_acc   = (state == READY) && !rst && b_en;
    assign waddr    = sweeping ? sweep_cnt : a_addr;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            logic                  lane_we;
            logic [LANE_WIDTH-1:0] lane_wdat;

            assign lane_we   = sweeping | (wr_ok & a_be[i]);
            assign lane_wdat = sweeping ? '0 : a_din[i*LANE_WIDTH +: LANE_WIDTH];

            bram_lane #(
                .LANE_WIDTH (LANE_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .we    (lane_we),
                .waddr (waddr),
                .wdat  (lane_wdat),
                .re    (rd_acc),
                .raddr (b_addr),
                .rdat  (lane_rdat[i*LANE_WIDTH +: LANE_WIDTH])
            );
        end
    endgenerate

`ifdef BANKED_LANE_BRAM_BYPASS_EN
    logic [NUM_LANES-1:0]  fwd_lane;
    logic [DATA_WIDTH-1:0] fwd_dat;

    // The lanes read old contents; remember which lanes were overwritten
    // in the read cycle and substitute the new bytes after the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_lane <= '0;
            fwd_dat  <= '0;
        end else if (rd_acc) begin
            fwd_lane <= (wr_ok && (a_addr == b_addr)) ? a_be : '0;
            fwd_dat  <= a_din;
        end
    end

    always_comb begin
        s1_dat = lane_rdat;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (fwd_lane[i]) begin
                s1_dat[i*LANE_WIDTH +: LANE_WIDTH] = fwd_dat[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end
`else
    assign s1_dat = lane_rdat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= rd_acc;
        end
    end

    generate
        if (READ_LATENCY == RD_LAT_2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_dat;
            logic                  s2_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_dat <= '0;
                    s2_vld <= 1'b0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign b_dout  = s2_dat;
            assign b_valid = s2_vld;
        end else begin : g_lat1
            assign b_dout  = s1_dat;
            assign b_valid = s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_banked_lane_bram.sv
// Directed bench for banked_lane_bram: latency-1 and latency-2 instances share stimulus
// and are checked every cycle against a memory/queue model, plus literal expectations.
module tb_banked_lane_bram;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_wen;
    logic [3:0]  a_be;
    logic [5:0]  a_addr;
    logic [31:0] a_din;
    logic        b_en;
    logic [5:0]  b_addr;

    logic        busy1, rdy1, v1;
    logic [31:0] dout1;
    logic        busy2, rdy2, v2;
    logic [31:0] dout2;

    always #5 clk = ~clk;

    banked_lane_bram #(.READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .init_busy(busy1), .a_ready(rdy1),
        .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .b_en(b_en), .b_addr(b_addr), .b_dout(dout1), .b_valid(v1)
    );

    banked_lane_bram #(.READ_LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .init_busy(busy2), .a_ready(rdy2),
        .a_wen(a_wen), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .b_en(b_en), .b_addr(b_addr), .b_dout(dout2), .b_valid(v2)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] dat;
    } rd_t;

    logic [31:0] mdl_mem [DEPTH];
    rd_t         q1[$];
    rd_t         q2[$];
    int          sweep_left = DEPTH;
    int          edge_n     = 0;
    logic [31:0] last1      = '0;
    logic [31:0] last2      = '0;
    bit          chk_en     = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [31:0] rv;
        edge_n++;
        if (rst) begin
            sweep_left = DEPTH;
            q1.delete();
            q2.delete();
            last1 = '0;
            last2 = '0;
        end else if (sweep_left > 0) begin
            mdl_mem[DEPTH - sweep_left] = '0;
            sweep_left--;
        end else begin
            rv = mdl_mem[b_addr];
            if (a_wen) mdl_mem[a_addr] = merge(mdl_mem[a_addr], a_din, a_be);
`ifdef BANKED_LANE_BRAM_BYPASS_EN
            if (a_wen && a_addr == b_addr) rv = mdl_mem[b_addr];
`endif
            if (b_en) begin
                q1.push_back('{edge_n, rv});
                q2.push_back('{edge_n + 1, rv});
            end
        end
    end

    always @(negedge clk) begin
        bit exp_busy, ev1, ev2;
        if (chk_en) begin
            exp_busy = (sweep_left > 0);
            ev1 = (q1.size() > 0) && (q1[0].due == edge_n);
            ev2 = (q2.size() > 0) && (q2[0].due == edge_n);
            if (ev1) begin last1 = q1[0].dat; void'(q1.pop_front()); end
            if (ev2) begin last2 = q2[0].dat; void'(q2.pop_front()); end
            chk("busy1",  32'(busy1), 32'(exp_busy));
            chk("ready1", 32'(rdy1),  32'(!exp_busy));
            chk("valid1", 32'(v1),    32'(ev1));
            chk("dout1",  dout1,      last1);
            chk("busy2",  32'(busy2), 32'(exp_busy));
            chk("ready2", 32'(rdy2),  32'(!exp_busy));
            chk("valid2", 32'(v2),    32'(ev2));
            chk("dout2",  dout2,      last2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        a_wen = 1'b0; a_be = 4'h0; a_addr = '0; a_din = '0;
        b_en  = 1'b0; b_addr = '0;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] d, input logic [3:0] be);
        a_wen = 1'b1; a_addr = addr; a_din = d; a_be = be;
        @(posedge clk); #1;
        a_wen = 1'b0;
    endtask

    task automatic read_lit(input string name, input logic [5:0] addr, input logic [31:0] exp);
        bit          found;
        logic [31:0] got;
        found = 1'b0;
        got   = '0;
        b_en = 1'b1; b_addr = addr;
        @(posedge clk); #1;
        b_en = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (v1) begin found = 1'b1; got = dout1; end
        end
        chk({name, "_vld"}, 32'(found), 32'd1);
        chk(name, got, exp);
    endtask

    task automatic count_busy(input string name);
        int nb;
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy1) break;
            nb++;
        end
        chk(name, 32'(nb), 32'd64);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        lv [5];
        logic [31:0] ld [5];

        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_dout",  dout1,       32'h0);
        chk("rst_busy",  32'(busy1),  32'd1);
        chk("rst_valid", 32'(v2),     32'd0);

        // Release reset while hammering both ports; everything must be dropped.
        a_wen = 1'b1; a_be = 4'hF; a_addr = 6'd3; a_din = 32'hFFFF_FFFF;
        b_en  = 1'b1; b_addr = 6'd3;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy("sweep_len");
        idle();

        for (int a = 0; a < DEPTH; a++) begin
            b_en = 1'b1; b_addr = 6'(a);
            @(posedge clk); #1;
        end
        b_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        read_lit("sweep_addr3", 6'd3, 32'h0);

        wr(6'd5, 32'hAABB_CCDD, 4'b1111);
        wr(6'd5, 32'h1122_3344, 4'b0101);
        wr(6'd5, 32'hFFFF_FFFF, 4'b0000);
        read_lit("byte_en", 6'd5, 32'hAA22_CC44);

        wr(6'd1, 32'h0101_0101, 4'hF);
        wr(6'd2, 32'h0202_0202, 4'hF);
        wr(6'd3, 32'h0303_0303, 4'hF);
        for (int i = 0; i < 5; i++) begin
            b_en = (i < 3); b_addr = 6'(i + 1);
            @(posedge clk);
            @(negedge clk);
            lv[i] = v2; ld[i] = dout2;
        end
        b_en = 1'b0;
        chk("lat2_v0", 32'(lv[0]), 32'd0);
        chk("lat2_v1", 32'(lv[1]), 32'd1);
        chk("lat2_v2", 32'(lv[2]), 32'd1);
        chk("lat2_v3", 32'(lv[3]), 32'd1);
        chk("lat2_v4", 32'(lv[4]), 32'd0);
        chk("lat2_d1", ld[1], 32'h0101_0101);
        chk("lat2_d2", ld[2], 32'h0202_0202);
        chk("lat2_d3", ld[3], 32'h0303_0303);

        a_wen = 1'b1; a_addr = 6'd9; a_din = 32'hDEAD_BEEF; a_be = 4'b1100;
        b_en  = 1'b1; b_addr = 6'd9;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("coll_vld", 32'(v1), 32'd1);
`ifdef BANKED_LANE_BRAM_BYPASS_EN
        chk("coll_dat", dout1, 32'hDEAD_0000);
`else
        chk("coll_dat", dout1, 32'h0000_0000);
`endif
        read_lit("coll_after", 6'd9, 32'hDEAD_0000);

        wr(6'd10, 32'h1234_5678, 4'hF);
        b_en = 1'b1; b_addr = 6'd10;
        @(posedge clk); #1;
        b_en = 1'b0;
        a_wen = 1'b1; a_addr = 6'd10; a_din = 32'hCAFE_F00D; a_be = 4'hF;
        @(posedge clk); #1;
        a_wen = 1'b0;
        @(negedge clk);
        chk("war_lat2_vld", 32'(v2), 32'd1);
        chk("war_lat2_dat", dout2, 32'h1234_5678);

        // Reset with a latency-2 read still in flight.
        b_en = 1'b1; b_addr = 6'd10;
        @(posedge clk); #1;
        b_en = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("inflight_v2", 32'(v2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy("resweep_len");
        @(posedge clk); #1;
        read_lit("resweep_addr5",  6'd5,  32'h0);
        read_lit("resweep_addr10", 6'd10, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
